// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32I pipeline: opcodes, control codes and immediate formats.
package riscv_pkg;
  localparam int XLEN      = 32;
  localparam int REG_COUNT = 32;
  localparam int REG_AW    = 5;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] ALUCTRL_ADD = 3'b000;
  localparam logic [2:0] ALUCTRL_SUB = 3'b001;
  localparam logic [2:0] ALUCTRL_AND = 3'b010;
  localparam logic [2:0] ALUCTRL_OR  = 3'b011;
  localparam logic [2:0] ALUCTRL_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
endpackage

// File: rtl/reg_file.sv
// Architectural register file: two combinational read ports, one write port, x0 hardwired
// to zero, and write-through so a same-cycle writeback is visible to the reading instruction.
module reg_file
  import riscv_pkg::*;
#(
  parameter int W = XLEN,
  parameter int N = REG_COUNT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [W-1:0]      wd,
  output logic [W-1:0]      rd1,
  output logic [W-1:0]      rd2
);
  logic [W-1:0] regs [N];
  logic         wr_en;

  assign wr_en = we && (wa != '0);

  // NOTE: the array is reset explicitly because reset must clear every architectural
  // register; that forces flops rather than a RAM macro, which is acceptable at 32x32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wa] <= wd;
    end
  end

  always_comb begin
    if (ra1 == '0)                  rd1 = '0;
    else if (wr_en && (wa == ra1))  rd1 = wd;
    else                            rd1 = regs[ra1];

    if (ra2 == '0)                  rd2 = '0;
    else if (wr_en && (wa == ra2))  rd2 = wd;
    else                            rd2 = regs[ra2];
  end
endmodule

// File: rtl/decode_stage.sv
// RV32I ID stage: register read, control/ALU decode, immediate extension and the ID/EX
// pipeline register with bubble insertion on FlushE.
module decode_stage
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   InstrD,
  input  logic [XLEN-1:0]   PCD,
  input  logic [XLEN-1:0]   PCPlus4D,
  input  logic              FlushE,
  input  logic              RegWriteW,
  input  logic [REG_AW-1:0] RdW,
  input  logic [XLEN-1:0]   ResultW,
  output logic [REG_AW-1:0] Rs1D,
  output logic [REG_AW-1:0] Rs2D,
  output logic              RegWriteE,
  output logic              MemWriteE,
  output logic              JumpE,
  output logic              BranchE,
  output logic              ALUSrcE,
  output logic [1:0]        ResultSrcE,
  output logic [2:0]        ALUControlE,
  output logic [XLEN-1:0]   RD1E,
  output logic [XLEN-1:0]   RD2E,
  output logic [XLEN-1:0]   ImmExtE,
  output logic [XLEN-1:0]   PCE,
  output logic [XLEN-1:0]   PCPlus4E,
  output logic [REG_AW-1:0] Rs1E,
  output logic [REG_AW-1:0] Rs2E,
  output logic [REG_AW-1:0] RdE
);
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rd1, rd2;

  logic            reg_write, mem_write, jump, branch, alu_src, imm_zero;
  logic [1:0]      imm_src, result_src, alu_op;
  logic [2:0]      alu_control;
  logic [XLEN-1:0] imm_ext;

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign Rs1D   = InstrD[19:15];
  assign Rs2D   = InstrD[24:20];

  reg_file u_reg_file (
    .clk (clk),
    .rst (rst),
    .ra1 (Rs1D),
    .ra2 (Rs2D),
    .we  (RegWriteW),
    .wa  (RdW),
    .wd  (ResultW),
    .rd1 (rd1),
    .rd2 (rd2)
  );

  // NOTE: every output is given a default before the case so no path leaves one
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    jump       = 1'b0;
    branch     = 1'b0;
    alu_src    = 1'b0;
    imm_zero   = 1'b0;
    imm_src    = IMM_I;
    result_src = RES_ALU;
    alu_op     = ALUOP_ADD;
    unique case (opcode)
      OP_LW:   begin reg_write = 1'b1; alu_src = 1'b1; result_src = RES_MEM; end
      OP_SW:   begin imm_src = IMM_S; alu_src = 1'b1; mem_write = 1'b1; end
      OP_R:    begin reg_write = 1'b1; alu_op = ALUOP_FUNCT; imm_zero = 1'b1; end
      OP_BEQ:  begin imm_src = IMM_B; branch = 1'b1; alu_op = ALUOP_SUB; end
      OP_IALU: begin reg_write = 1'b1; alu_src = 1'b1; alu_op = ALUOP_FUNCT; end
      OP_JAL:  begin reg_write = 1'b1; imm_src = IMM_J; result_src = RES_PC4; jump = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    alu_control = ALUCTRL_ADD;
    if (alu_op == ALUOP_SUB) begin
      alu_control = ALUCTRL_SUB;
    end else if (alu_op == ALUOP_FUNCT) begin
      case (funct3)
        3'b000:  alu_control = (opcode[5] && InstrD[30]) ? ALUCTRL_SUB : ALUCTRL_ADD;
        3'b010:  alu_control = ALUCTRL_SLT;
        3'b110:  alu_control = ALUCTRL_OR;
        3'b111:  alu_control = ALUCTRL_AND;
        default: alu_control = ALUCTRL_ADD;
      endcase
    end
  end

  always_comb begin
    unique case (imm_src)
      IMM_I:   imm_ext = {{20{InstrD[31]}}, InstrD[31:20]};
      IMM_S:   imm_ext = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      IMM_B:   imm_ext = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      default: imm_ext = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
    endcase
    if (imm_zero) imm_ext = '0;
  end

  // NOTE: pipeline state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || FlushE) begin
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      JumpE       <= 1'b0;
      BranchE     <= 1'b0;
      ALUSrcE     <= 1'b0;
      ResultSrcE  <= '0;
      ALUControlE <= '0;
      RD1E        <= '0;
      RD2E        <= '0;
      ImmExtE     <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
      Rs1E        <= '0;
      Rs2E        <= '0;
      RdE         <= '0;
    end else begin
      RegWriteE   <= reg_write;
      MemWriteE   <= mem_write;
      JumpE       <= jump;
      BranchE     <= branch;
      ALUSrcE     <= alu_src;
      ResultSrcE  <= result_src;
      ALUControlE <= alu_control;
      RD1E        <= rd1;
      RD2E        <= rd2;
      ImmExtE     <= imm_ext;
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
      Rs1E        <= Rs1D;
      Rs2E        <= Rs2D;
      RdE         <= InstrD[11:7];
    end
  end
endmodule
